// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   - arb_state_e : arbiter state encoding (also exported as a debug port)
//   - OWN_*       : requester identities used for owner/last_owner/grant ids
//   - RW_*        : RAM access type encoding
//   - CNT_W       : width of the RAM latency counter (RAM_LAT is 1..7)
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_DONE    = 2'd2,
    ARB_ILLEGAL = 2'd3
  } arb_state_e;

  localparam logic OWN_CACHE = 1'b0;
  localparam logic OWN_DMA   = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters (data cache, DMA), the arbiter and
// the single-port data RAM.
//   c_*   : cache request/response (req, rw, addr, wdata in; rdata, ack out)
//   d_*   : DMA request/response, same shape as c_*
//   ram_* : RAM command (en, rw, addr, wdata) and read data (rdata)
//   owner, busy, arb_state : status/debug outputs of the arbiter
// Modport slave is the arbiter; modport master is its environment.
interface ram_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();

  logic          c_req;
  logic          c_rw;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [DW-1:0] c_rdata;
  logic          c_ack;

  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          ram_en;
  logic          ram_rw;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          owner;
  logic          busy;
  logic [1:0]    arb_state;

  modport slave (
    input  c_req, c_rw, c_addr, c_wdata,
    output c_rdata, c_ack,
    input  d_req, d_rw, d_addr, d_wdata,
    output d_rdata, d_ack,
    output ram_en, ram_rw, ram_addr, ram_wdata,
    input  ram_rdata,
    output owner, busy, arb_state
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata,
    input  c_rdata, c_ack,
    output d_req, d_rw, d_addr, d_wdata,
    input  d_rdata, d_ack,
    input  ram_en, ram_rw, ram_addr, ram_wdata,
    output ram_rdata,
    input  owner, busy, arb_state
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   req[1:0]    : request vector, index = requester id
//   last_owner  : id that won the previous grant
//   grant_valid : at least one request is present
//   grant_id    : winning id; on a tie the requester that is not last_owner
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    grant_valid = |req;
    grant_id    = 1'b0;
    if (req == 2'b11) begin
      grant_id = ~last_owner;
    end else begin
      grant_id = req[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the data cache and the input DMA.
// One access at a time: grant in IDLE, hold ram_en for RAM_LAT cycles in
// ACCESS, pulse the winner's ack for one cycle in DONE, then back to IDLE.
// Ties alternate between the requesters.
//   g_clk : clock, rising edge
//   g_clr : asynchronous active-high reset
//   bus   : slave side of ram_port_arbiter_if (requesters, RAM, status)
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 2
) (
  input  logic                  g_clk,
  input  logic                  g_clr,
  ram_port_arbiter_if.slave     bus
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic             ram_rw_q, ram_rw_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic [DW-1:0]    c_rdata_q, c_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;

  logic grant_valid;
  logic grant_id;

  // Bit index equals OWN_* id: bit 0 is the cache, bit 1 the DMA.
  rr_pick2 u_pick (
    .req         ({bus.d_req, bus.c_req}),
    .last_owner  (last_owner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    ram_rw_d     = ram_rw_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    c_rdata_d    = c_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          state_d      = ARB_ACCESS;
          owner_d      = grant_id;
          last_owner_d = grant_id;
          cnt_d        = CNT_W'(RAM_LAT - 1);
          // The command is frozen here; later requester changes are ignored.
          if (grant_id == OWN_DMA) begin
            ram_rw_d    = bus.d_rw;
            ram_addr_d  = bus.d_addr;
            ram_wdata_d = bus.d_wdata;
          end else begin
            ram_rw_d    = bus.c_rw;
            ram_addr_d  = bus.c_addr;
            ram_wdata_d = bus.c_wdata;
          end
        end
      end

      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          // Last ram_en cycle: read data is valid now.
          if (ram_rw_q == RW_READ) begin
            if (owner_q == OWN_DMA) begin
              d_rdata_d = bus.ram_rdata;
            end else begin
              c_rdata_d = bus.ram_rdata;
            end
          end
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ARB_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge g_clk or posedge g_clr) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (g_clr) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CACHE;
      last_owner_q <= OWN_DMA;    // cache wins the first tie
      ram_rw_q     <= RW_READ;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ram_rw_q     <= ram_rw_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      c_rdata_q    <= c_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free
  // and fall immediately when g_clr is asserted.
  assign bus.ram_en    = (state_q == ARB_ACCESS);
  assign bus.ram_rw    = ram_rw_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.c_ack     = (state_q == ARB_DONE) && (owner_q == OWN_CACHE);
  assign bus.d_ack     = (state_q == ARB_DONE) && (owner_q == OWN_DMA);
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == ARB_ACCESS) || (state_q == ARB_DONE);
  assign bus.arb_state = state_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sequences and shares the single-port data RAM between two requesters:
  - the data cache (miss refill and write-back);
  - an input-device DMA channel that stores bytes from input_bus without stalling stage1.
- Sits between the cache/DMA blocks and the RAM inside the processor.
- Issues one RAM access at a time, holds it for a fixed RAM latency, returns read data and a one-cycle ack, and alternates ownership round-robin under contention.

Parameters:
- AW, 8, address width (the data RAM is 8-bit addressed).
- DW, 8, data width.
- RAM_LAT, 2, cycles ram_en is held per access; legal range 1..7.

Ports:
- g_clk  in  1  global clock, rising edge.
- g_clr  in  1  reset, asynchronous, active-high.
- c_req  in  1  cache requests an access.
- c_rw  in  1  cache access type: 1 = write, 0 = read.
- c_addr  in  AW  cache address.
- c_wdata  in  DW  cache write data.
- c_rdata  out  DW  cache read data; valid while c_ack = 1 and held afterwards.
- c_ack  out  1  one-cycle completion pulse to the cache.
- d_req, d_rw, d_addr, d_wdata, d_rdata, d_ack: identical set for the DMA channel.
- ram_en  out  1  RAM enable.
- ram_rw  out  1  RAM access type: 1 = write.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data; valid by the final cycle of ram_en.
- owner  out  1  current or last grant: 0 = cache, 1 = DMA.
- busy  out  1  high in ACCESS and DONE.
- arb_state  out  2  state encoding, for debug.

Behaviour:
- Reset (g_clr high, any time, including mid-access):
  - State goes to IDLE immediately.
  - ram_en, ram_rw, c_ack, d_ack and busy are 0.
  - ram_addr, ram_wdata, c_rdata and d_rdata are 0.
  - owner is 0; last_owner is 1, so the cache wins the first tie.
  - An interrupted access is abandoned and gets no ack.
- States: IDLE = 0, ACCESS = 1, DONE = 2. Encoding 3 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - Samples c_req and d_req.
  - Only one asserted: grant that requester.
  - Both asserted: grant the requester that is not last_owner.
  - Neither asserted: stay in IDLE.
  - On a grant:
    - Latch rw, addr and wdata of the winner into the RAM output registers.
    - Set owner and last_owner to the winner.
    - Load the latency counter with RAM_LAT-1 and go to ACCESS.
- ACCESS:
  - ram_en = 1 and the RAM outputs are stable.
  - The counter decrements each cycle.
  - When the counter is 0:
    - On a read, capture ram_rdata into the winner's rdata register.
    - Go to DONE.
  - Requester address and data changes after the grant are ignored, because they were latched at the grant.
- DONE:
  - ram_en = 0.
  - The winner's ack = 1 for exactly this cycle.
  - Go to IDLE.
- Timing: a request first high in cycle 0 is granted at the end of cycle 0.
  - ram_en is high in cycles 1..RAM_LAT.
  - ack is high in cycle RAM_LAT+1.
  - Best-case latency is RAM_LAT+1 cycles; throughput is one access per RAM_LAT+2 cycles.
- Requester rules: hold req until ack; drop req on the edge after ack.
  - A req still high in the IDLE following its own DONE is treated as a new request.
  - Dropping req during ACCESS does not cancel the access; its ack is still pulsed.
- Writes: the rdata registers are unchanged; the ack still pulses.
- The non-owner's ack is never high. c_ack and d_ack are never high together.
- Fairness: under continuous contention, grants alternate C, D, C, D. Neither requester waits more than one foreign access.

Decomposition:
- Shared package ram_arb_pkg:
  - State encodings ARB_IDLE, ARB_ACCESS, ARB_DONE.
  - Owner constants OWN_CACHE = 0, OWN_DMA = 1.
  - RW_READ = 0, RW_WRITE = 1.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: grant_valid, grant_id.
  - Reused later for interrupt/stack sharing.

Test Plan:
- Reset, then a single cache read of addr 0x05 with ram_rdata = 0x3C, RAM_LAT = 2 -> ram_en high in cycles 1–2 with ram_addr = 0x05 and ram_rw = 0; c_ack high in cycle 3 only; c_rdata = 0x3C; d_ack stays 0.
- DMA write of 0xA7 to 0x0E -> ram_rw = 1, ram_wdata = 0xA7 for 2 cycles; d_ack pulses in cycle 3; d_rdata unchanged at 0.
- c_req and d_req raised in the same cycle after reset, both held until ack -> cache served first (c_ack in cycle 3); DMA granted in IDLE cycle 4 (d_ack in cycle 7); owner sequence 0 then 1.
- Both requesters continuously re-requesting for 4 accesses -> grants alternate C, D, C, D; acks are never coincident.
- Requester changes c_addr from 0x05 to 0x09 in cycle 1 of its access -> ram_addr stays 0x05 for the whole access.
- g_clr pulsed in cycle 1 of an access -> ram_en drops at once; no ack is issued; state is IDLE; a tie on the next request is won by the cache.
